// File: rtl/csi_2_tx_packetizer_if.sv
// Handshake bundle for the CSI-2 TX packetizer: packet request, payload byte stream and framed byte output.
interface csi_2_tx_packetizer_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_vc_i;
  logic [5:0]  req_dt_i;
  logic [15:0] req_wc_i;
  logic [7:0]  in_data_i;
  logic        in_valid_i;
  logic        in_last_i;
  logic        in_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_sop_o;
  logic        tx_eop_o;
  logic        tx_ready_i;

  modport slave (
    input  req_valid_i, req_vc_i, req_dt_i, req_wc_i, in_data_i, in_valid_i, in_last_i, tx_ready_i,
    output req_ready_o, in_ready_o, tx_data_o, tx_valid_o, tx_sop_o, tx_eop_o
  );

  modport master (
    output req_valid_i, req_vc_i, req_dt_i, req_wc_i, in_data_i, in_valid_i, in_last_i, tx_ready_i,
    input  req_ready_o, in_ready_o, tx_data_o, tx_valid_o, tx_sop_o, tx_eop_o
  );
endinterface

// File: rtl/csi_2_tx_packetizer.sv
// Byte-serial CSI-2 packet builder: sync, 4-byte header, payload and CRC-16 behind one output register.
//  state     | meaning
//  S_IDLE    | output empty, waiting for a request
//  S_SYNC    | sync byte held in the output register
//  S_HDR     | header byte r_hdr_idx (DI, WC lo, WC hi, ECC) held in the output register
//  S_PAYLOAD | streaming payload (or zero padding) until r_rem reaches 0
//  S_CRC_LO  | crc[7:0] held in the output register
//  S_CRC_HI  | crc[15:8] held with eop
module csi_2_tx_packetizer #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hB8,
  parameter logic [15:0] CRC_INIT     = 16'hFFFF,
  parameter logic [5:0]  SHORT_DT_MAX = 6'h0F
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  csi_2_tx_packetizer_if.slave        bus,
  output logic                        busy_o,
  output logic                        len_err_o
);
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_HDR, S_PAYLOAD, S_CRC_LO, S_CRC_HI} state_t;

  state_t      r_state, w_state_nx;
  logic [1:0]  r_vc, w_vc_nx;
  logic [5:0]  r_dt, w_dt_nx;
  logic [15:0] r_wc, w_wc_nx;
  logic [15:0] r_crc, w_crc_nx;
  logic [15:0] r_rem, w_rem_nx;
  logic        r_pad, w_pad_nx;
  logic [1:0]  r_hdr_idx, w_hdr_idx_nx;
  logic [7:0]  r_tx_data, w_tx_data_nx;
  logic        r_tx_valid, w_tx_valid_nx;
  logic        r_tx_sop, w_tx_sop_nx;
  logic        r_tx_eop, w_tx_eop_nx;
  logic        r_len_err, w_len_err_nx;

  logic        w_adv;
  logic        w_in_ready;
  logic        w_short;
  logic [7:0]  w_di;
  logic [7:0]  w_ecc;
  logic [7:0]  w_pay_byte;
  logic [15:0] w_crc_upd;

  // CRC-16 CCITT, poly 0x1021, MSB-first
  function automatic logic [15:0] f_crc16(input logic [7:0] i_byte, input logic [15:0] i_crc);
    logic [15:0] v_c;
    v_c = i_crc ^ {i_byte, 8'h00};
    for (int k = 0; k < 8; k++) begin
      v_c = v_c[15] ? ({v_c[14:0], 1'b0} ^ 16'h1021) : {v_c[14:0], 1'b0};
    end
    return v_c;
  endfunction

  assign w_adv      = !r_tx_valid | bus.tx_ready_i;
  assign w_in_ready = (r_state == S_PAYLOAD) & w_adv & (r_rem != 16'd0) & !r_pad;
  assign w_short    = (r_dt <= SHORT_DT_MAX);
  assign w_di       = {r_vc, r_dt};
  assign w_ecc      = w_di ^ r_wc[7:0] ^ r_wc[15:8];
  assign w_pay_byte = r_pad ? 8'h00 : bus.in_data_i;
  assign w_crc_upd  = f_crc16(w_pay_byte, r_crc);

  assign bus.req_ready_o = (r_state == S_IDLE);
  assign bus.in_ready_o  = w_in_ready;
  assign bus.tx_data_o   = r_tx_data;
  assign bus.tx_valid_o  = r_tx_valid;
  assign bus.tx_sop_o    = r_tx_sop;
  assign bus.tx_eop_o    = r_tx_eop;
  assign busy_o          = (r_state != S_IDLE);
  assign len_err_o       = r_len_err;

  always_comb begin
    w_state_nx    = r_state;
    w_vc_nx       = r_vc;
    w_dt_nx       = r_dt;
    w_wc_nx       = r_wc;
    w_crc_nx      = r_crc;
    w_rem_nx      = r_rem;
    w_pad_nx      = r_pad;
    w_hdr_idx_nx  = r_hdr_idx;
    w_tx_data_nx  = r_tx_data;
    w_tx_valid_nx = r_tx_valid;
    w_tx_sop_nx   = r_tx_sop;
    w_tx_eop_nx   = r_tx_eop;
    w_len_err_nx  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          w_vc_nx       = bus.req_vc_i;
          w_dt_nx       = bus.req_dt_i;
          w_wc_nx       = bus.req_wc_i;
          w_crc_nx      = CRC_INIT;
          w_pad_nx      = 1'b0;
          w_tx_data_nx  = SYNC_BYTE;
          w_tx_valid_nx = 1'b1;
          w_tx_sop_nx   = 1'b1;
          w_tx_eop_nx   = 1'b0;
          w_state_nx    = S_SYNC;
        end
      end
      S_SYNC: begin
        if (w_adv) begin
          w_tx_data_nx = w_di;
          w_tx_sop_nx  = 1'b0;
          w_hdr_idx_nx = 2'd0;
          w_state_nx   = S_HDR;
        end
      end
      S_HDR: begin
        if (w_adv) begin
          w_hdr_idx_nx = r_hdr_idx + 2'd1;
          case (r_hdr_idx)
            2'd0: w_tx_data_nx = r_wc[7:0];
            2'd1: w_tx_data_nx = r_wc[15:8];
            2'd2: begin
              w_tx_data_nx = w_ecc;
              w_tx_eop_nx  = w_short;
            end
            default: begin
              w_tx_eop_nx = 1'b0;
              if (w_short) begin
                w_tx_valid_nx = 1'b0;
                w_state_nx    = S_IDLE;
              end else if (r_wc == 16'd0) begin
                // empty long packet still carries the seed as its CRC
                w_tx_data_nx = r_crc[7:0];
                w_state_nx   = S_CRC_LO;
              end else begin
                w_tx_valid_nx = 1'b0;
                w_rem_nx      = r_wc;
                w_state_nx    = S_PAYLOAD;
              end
            end
          endcase
        end
      end
      S_PAYLOAD: begin
        if (w_adv) begin
          if (r_rem == 16'd0) begin
            w_tx_data_nx  = r_crc[7:0];
            w_tx_valid_nx = 1'b1;
            w_state_nx    = S_CRC_LO;
          end else if (r_pad || bus.in_valid_i) begin
            w_tx_data_nx  = w_pay_byte;
            w_tx_valid_nx = 1'b1;
            w_crc_nx      = w_crc_upd;
            w_rem_nx      = r_rem - 16'd1;
            if (!r_pad && bus.in_last_i && r_rem > 16'd1) begin
              w_pad_nx     = 1'b1;
              w_len_err_nx = 1'b1;
            end
            if (!r_pad && !bus.in_last_i && r_rem == 16'd1) begin
              w_len_err_nx = 1'b1;
            end
          end else begin
            w_tx_valid_nx = 1'b0;
          end
        end
      end
      S_CRC_LO: begin
        if (w_adv) begin
          w_tx_data_nx = r_crc[15:8];
          w_tx_eop_nx  = 1'b1;
          w_state_nx   = S_CRC_HI;
        end
      end
      S_CRC_HI: begin
        if (w_adv) begin
          w_tx_valid_nx = 1'b0;
          w_tx_eop_nx   = 1'b0;
          w_state_nx    = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_vc       <= 2'd0;
      r_dt       <= 6'd0;
      r_wc       <= 16'd0;
      r_crc      <= 16'd0;
      r_rem      <= 16'd0;
      r_pad      <= 1'b0;
      r_hdr_idx  <= 2'd0;
      r_tx_data  <= 8'd0;
      r_tx_valid <= 1'b0;
      r_tx_sop   <= 1'b0;
      r_tx_eop   <= 1'b0;
      r_len_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_vc       <= w_vc_nx;
      r_dt       <= w_dt_nx;
      r_wc       <= w_wc_nx;
      r_crc      <= w_crc_nx;
      r_rem      <= w_rem_nx;
      r_pad      <= w_pad_nx;
      r_hdr_idx  <= w_hdr_idx_nx;
      r_tx_data  <= w_tx_data_nx;
      r_tx_valid <= w_tx_valid_nx;
      r_tx_sop   <= w_tx_sop_nx;
      r_tx_eop   <= w_tx_eop_nx;
      r_len_err  <= w_len_err_nx;
    end
  end
endmodule

// File: tb/tb_csi_2_tx_packetizer.sv
// Bench for csi_2_tx_packetizer: packet-level byte model, randomized payload/back-pressure, per-byte compare.
module tb_csi_2_tx_packetizer;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic busy_o, len_err_o;

  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q[$];      // {sop, eop, byte}
  logic [7:0] src_q[$];
  int rdy_mode = 0;          // 0 always ready, 1 toggle, 2 random
  bit gaps = 1'b0;
  int err_seen = 0;
  bit stall_v = 1'b0;
  logic [9:0] stall_d;

  csi_2_tx_packetizer_if bus();

  csi_2_tx_packetizer dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bus       (bus),
    .busy_o    (busy_o),
    .len_err_o (len_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // CRC over a whole message, bit by bit
  function automatic logic [15:0] crc_msg(input logic [7:0] m[$]);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    foreach (m[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ m[i][b];
        c = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  // Appends the expected framed packet to exp_q; returns expected number of len_err pulses.
  function automatic int model_packet(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
    logic [7:0] di, ecc;
    logic [7:0] pl[$];
    logic [15:0] c;
    int n;
    di  = {vc, dt};
    ecc = di ^ wc[7:0] ^ wc[15:8];
    exp_q.push_back({2'b10, 8'hB8});
    exp_q.push_back({2'b00, di});
    exp_q.push_back({2'b00, wc[7:0]});
    exp_q.push_back({2'b00, wc[15:8]});
    if (dt <= 6'h0F) begin
      exp_q.push_back({2'b01, ecc});
      return 0;
    end
    exp_q.push_back({2'b00, ecc});
    n = src_q.size();
    for (int i = 0; i < int'(wc); i++) pl.push_back(i < n ? src_q[i] : 8'h00);
    c = crc_msg(pl);
    foreach (pl[i]) exp_q.push_back({2'b00, pl[i]});
    exp_q.push_back({2'b00, c[7:0]});
    exp_q.push_back({2'b01, c[15:8]});
    return (wc != 16'd0 && n != int'(wc)) ? 1 : 0;
  endfunction

  task automatic pin_check(input string name, input logic [7:0] lit[$]);
    int last;
    last = lit.size() - 1;
    chk({name, "_len"}, exp_q.size(), lit.size());
    for (int i = 0; i < lit.size() && i < exp_q.size(); i++)
      chk({name, "_byte"}, exp_q[i], {(i == 0), (i == last), lit[i]});
    exp_q.delete();
  endtask

  always @(posedge clk_i) begin
    #1;
    case (rdy_mode)
      0:       bus.tx_ready_i = 1'b1;
      1:       bus.tx_ready_i = ~bus.tx_ready_i;
      default: bus.tx_ready_i = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk_i) begin
    logic [9:0] cur, e;
    if (rst_i) begin
      exp_q.delete();
      stall_v = 1'b0;
    end else begin
      cur = {bus.tx_sop_o, bus.tx_eop_o, bus.tx_data_o};
      if (len_err_o) err_seen++;
      if (!busy_o) chk("in_ready_idle", bus.in_ready_o, 0);
      if (bus.tx_valid_o === 1'b1) begin
        if (stall_v) chk("stall_hold", cur, stall_d);
        if (bus.tx_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte actual=%0h required=none", cur);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte", cur, e);
          end
          stall_v = 1'b0;
        end else begin
          stall_v = 1'b1;
          stall_d = cur;
        end
      end else begin
        if (stall_v) chk("stall_valid", bus.tx_valid_o, 1);
        stall_v = 1'b0;
      end
    end
  end

  task automatic present(input int idx, input int n);
    if (idx < n) begin
      bus.in_valid_i = !gaps || ($urandom_range(0, 2) != 0);
      bus.in_data_i  = src_q[idx];
      bus.in_last_i  = (idx == n - 1);
    end else begin
      bus.in_valid_i = 1'b0;
      bus.in_data_i  = 8'h00;
      bus.in_last_i  = 1'b0;
    end
  endtask

  task automatic run_packet(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                            input int abort_at);
    int idx, cyc, n, exp_err, exp_take, base;
    bit req_done, done, aborted, req_hs, in_hs;
    n        = src_q.size();
    exp_err  = model_packet(vc, dt, wc);
    exp_take = (dt <= 6'h0F || wc == 16'd0) ? 0 : ((n < int'(wc)) ? n : int'(wc));
    base     = err_seen;
    idx = 0; cyc = 0; req_done = 0; done = 0; aborted = 0;
    bus.req_vc_i    = vc;
    bus.req_dt_i    = dt;
    bus.req_wc_i    = wc;
    bus.req_valid_i = 1'b1;
    present(idx, n);
    while (!done && !aborted && cyc < 5000) begin
      @(negedge clk_i);
      req_hs = bus.req_valid_i & bus.req_ready_o;
      in_hs  = bus.in_valid_i & bus.in_ready_o;
      @(posedge clk_i);
      #1;
      cyc++;
      if (req_hs) begin
        bus.req_valid_i = 1'b0;
        req_done = 1'b1;
      end
      if (in_hs) idx++;
      if (in_hs || !bus.in_valid_i) present(idx, n);
      if (abort_at >= 0 && idx >= abort_at) aborted = 1'b1;
      if (req_done && !busy_o && exp_q.size() == 0) done = 1'b1;
    end
    if (!aborted) begin
      chk("packet_done", done, 1);
      chk("len_err_count", err_seen - base, exp_err);
      chk("bytes_taken", idx, exp_take);
    end
    bus.in_valid_i  = 1'b0;
    bus.in_last_i   = 1'b0;
    bus.req_valid_i = 1'b0;
  endtask

  initial begin
    logic [7:0] lit[$];
    logic [1:0] vc;
    logic [5:0] dt;
    logic [15:0] wc;
    int n;
    bus.req_valid_i = 1'b0;
    bus.req_vc_i    = 2'd0;
    bus.req_dt_i    = 6'd0;
    bus.req_wc_i    = 16'd0;
    bus.in_data_i   = 8'd0;
    bus.in_valid_i  = 1'b0;
    bus.in_last_i   = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_tx_valid", bus.tx_valid_o, 0);
    chk("rst_tx_sop", bus.tx_sop_o, 0);
    chk("rst_tx_eop", bus.tx_eop_o, 0);
    chk("rst_tx_data", bus.tx_data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_len_err", len_err_o, 0);
    chk("rst_req_ready", bus.req_ready_o, 1);
    chk("rst_in_ready", bus.in_ready_o, 0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // model pins
    src_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("pin_crc", crc_msg(src_q), 16'h29B1);
    n = model_packet(2'd1, 6'h2B, 16'd9);
    chk("pin1_err", n, 0);
    lit = {8'hB8, 8'h6B, 8'h09, 8'h00, 8'h62, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
           8'h37, 8'h38, 8'h39, 8'hB1, 8'h29};
    pin_check("pin1", lit);
    src_q.delete();
    void'(model_packet(2'd0, 6'h00, 16'h1234));
    lit = {8'hB8, 8'h00, 8'h34, 8'h12, 8'h26};
    pin_check("pin2", lit);
    void'(model_packet(2'd0, 6'h2A, 16'd0));
    lit = {8'hB8, 8'h2A, 8'h00, 8'h00, 8'h2A, 8'hFF, 8'hFF};
    pin_check("pin5", lit);

    // long packet, full throughput
    src_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    run_packet(2'd1, 6'h2B, 16'd9, -1);
    // short packet with a payload byte on offer that must not be taken
    src_q = {8'h5A};
    run_packet(2'd0, 6'h00, 16'h1234, -1);
    // same long packet under alternating back-pressure
    rdy_mode = 1;
    src_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    run_packet(2'd1, 6'h2B, 16'd9, -1);
    rdy_mode = 0;
    // early last: padded to wc
    src_q = {8'hAA, 8'hBB};
    run_packet(2'd2, 6'h2C, 16'd4, -1);
    // empty long packet
    src_q.delete();
    run_packet(2'd0, 6'h2A, 16'd0, -1);
    // missing last: closes at wc
    src_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_packet(2'd3, 6'h1E, 16'd3, -1);

    // reset mid-payload
    src_q.delete();
    for (int k = 0; k < 20; k++) src_q.push_back(8'(k + 8'h40));
    run_packet(2'd1, 6'h2B, 16'd20, 5);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_tx_valid", bus.tx_valid_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_req_ready", bus.req_ready_o, 1);
    @(posedge clk_i);
    #1;
    src_q = {8'h11, 8'h22, 8'h33};
    run_packet(2'd0, 6'h24, 16'd3, -1);

    // randomized packets under random back-pressure and source gaps
    rdy_mode = 2;
    gaps = 1'b1;
    for (int p = 0; p < 40; p++) begin
      vc = 2'($urandom);
      dt = 6'($urandom);
      wc = 16'($urandom_range(0, 24));
      if (wc == 16'd0) n = int'($urandom_range(0, 2));
      else begin
        n = int'(wc) + int'($urandom_range(0, 4)) - 2;
        if (n < 1) n = 1;
      end
      src_q.delete();
      for (int k = 0; k < n; k++) src_q.push_back(8'($urandom));
      run_packet(vc, dt, wc, -1);
    end
    // WC with a non-zero high byte
    src_q.delete();
    for (int k = 0; k < 260; k++) src_q.push_back(8'($urandom));
    run_packet(2'd2, 6'h2B, 16'd260, -1);

    repeat (3) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
